// File: rtl/regPKG.sv
// Shared register-bus types and SPI frame geometry for the SPI-to-register bridge.
// Contents: address/data widths and types, frame/command bit counts, counter width.
package regPKG;

    localparam int REG_ADDRWIDTH = 4;
    localparam int REG_DATAWIDTH = 16;

    typedef logic [REG_ADDRWIDTH-1:0] reg_addr_t;
    typedef logic [REG_DATAWIDTH-1:0] reg_data_t;

    localparam int SPI_FRAME_BITS = 24;
    localparam int SPI_CMD_BITS   = 8;

    // Bit counter must reach SPI_FRAME_BITS.
    localparam int SPI_CNT_W = $clog2(SPI_FRAME_BITS + 1);

endpackage

// File: rtl/spi_in_sync.sv
// N-flop synchronizer for one asynchronous SPI pin, with rise/fall detect.
// Ports: clk, rst (sync, active-high), din (async pin), lvl (synced level),
//        rise/fall (one-cycle pulses on synced level transitions).
module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            hist  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            hist  <= chain[STAGES-1];
        end
    end

    assign lvl  = chain[STAGES-1];
    assign rise = lvl & ~hist;
    assign fall = ~lvl & hist;

endmodule

// File: rtl/reg_spi_bridge.sv
// SPI (mode 0) slave to register-bus bridge: 24-bit frames {RW,rsv[2:0],addr[3:0],data[15:0]}.
// Ports: clk, rst (sync, active-high), sclk/cs_n/mosi (async SPI in), miso,
//        reg_addr, reg_wdata, reg_we, reg_re (bus out), reg_rdata (bus in, one clk after reg_re).
module reg_spi_bridge
    import regPKG::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      sclk,
    input  logic      cs_n,
    input  logic      mosi,
    output logic      miso,
    output reg_addr_t reg_addr,
    output reg_data_t reg_wdata,
    output logic      reg_we,
    output logic      reg_re,
    input  reg_data_t reg_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        TAIL
    } state_t;

    localparam logic [SPI_CNT_W-1:0] CMD_LAST   = SPI_CNT_W'(SPI_CMD_BITS - 1);
    localparam logic [SPI_CNT_W-1:0] FRAME_LAST = SPI_CNT_W'(SPI_FRAME_BITS - 1);
    localparam logic [2:0]           SETTLE     = 3'(SYNC_STAGES + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .din (sclk),
        .lvl (sclk_lvl),
        .rise(sclk_rise),
        .fall(sclk_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .din (cs_n),
        .lvl (cs_lvl),
        .rise(cs_rise),
        .fall(cs_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .din (mosi),
        .lvl (mosi_lvl),
        .rise(mosi_rise),
        .fall(mosi_fall)
    );

    assign unused_edges = ^{sclk_lvl, mosi_rise, mosi_fall};

    state_t                 state;
    logic [SPI_CNT_W-1:0]   cnt;
    // Only the last 15 bits are ever needed: bit 6 holds RW at the 8th
    // rising edge, and the low 15 bits plus mosi form the data word.
    logic [REG_DATAWIDTH-2:0] sh_in;
    reg_data_t              sh_out;
    logic                   rw;
    logic                   cap;
    logic                   we_pend;
    // After reset the cs_n synchronizer starts high; if the pin is really
    // low this would look like a falling edge. A frame is only accepted
    // once cs_n has been seen high after the chain has settled.
    logic                   armed;
    logic [2:0]             settle;
    logic                   settle_done;

    assign settle_done = (settle == SETTLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sh_in     <= '0;
            sh_out    <= '0;
            rw        <= 1'b0;
            cap       <= 1'b0;
            we_pend   <= 1'b0;
            armed     <= 1'b0;
            settle    <= '0;
            miso      <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            reg_we  <= we_pend;
            we_pend <= 1'b0;
            reg_re  <= 1'b0;
            cap     <= reg_re;

            if (!settle_done) begin
                settle <= settle + 3'd1;
            end
            if (!armed && settle_done && cs_lvl) begin
                armed <= 1'b1;
            end

            if (state != IDLE && cs_rise) begin
                state <= IDLE;
                miso  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        miso <= 1'b0;
                        if (cs_fall && armed) begin
                            state  <= CMD;
                            cnt    <= '0;
                            sh_in  <= '0;
                            sh_out <= '0;
                        end
                    end

                    CMD: begin
                        miso <= 1'b0;
                        if (sclk_rise) begin
                            sh_in <= {sh_in[REG_DATAWIDTH-3:0], mosi_lvl};
                            cnt   <= cnt + 1'b1;
                            if (cnt == CMD_LAST) begin
                                rw       <= sh_in[SPI_CMD_BITS-2];
                                reg_addr <= {sh_in[REG_ADDRWIDTH-2:0], mosi_lvl};
                                reg_re   <= ~sh_in[SPI_CMD_BITS-2];
                                state    <= DATA;
                            end
                        end
                    end

                    DATA: begin
                        if (cap) begin
                            sh_out <= reg_rdata;
                        end else if (sclk_fall && !rw) begin
                            miso   <= sh_out[REG_DATAWIDTH-1];
                            sh_out <= {sh_out[REG_DATAWIDTH-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            sh_in <= {sh_in[REG_DATAWIDTH-3:0], mosi_lvl};
                            cnt   <= cnt + 1'b1;
                            if (cnt == FRAME_LAST) begin
                                if (rw) begin
                                    reg_wdata <= {sh_in, mosi_lvl};
                                    we_pend   <= 1'b1;
                                end
                                miso  <= 1'b0;
                                state <= TAIL;
                            end
                        end
                    end

                    TAIL: begin
                        miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reg_spi_bridge.sv
// Directed bench for reg_spi_bridge: SPI master driver, register-file model,
// per-cycle strobe/miso checker and per-frame end checks.
module tb_reg_spi_bridge;
    import regPKG::*;

    localparam int H = 5;

    logic      clk  = 1'b0;
    logic      rst  = 1'b1;
    logic      sclk = 1'b0;
    logic      cs_n = 1'b1;
    logic      mosi = 1'b0;
    logic      miso;
    reg_addr_t reg_addr;
    reg_data_t reg_wdata;
    logic      reg_we;
    logic      reg_re;
    reg_data_t reg_rdata = 16'hDEAD;

    always #5 clk = ~clk;

    reg_spi_bridge #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata)
    );

    int        tests = 0;
    int        fails = 0;
    int        n_we  = 0;
    int        n_re  = 0;
    logic      mz    = 1'b1;
    reg_addr_t cur_addr  = '0;
    reg_data_t cur_wdata = '0;
    reg_data_t mem [16];
    reg_addr_t m_addr  = '0;
    reg_data_t m_wdata = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Register file answering read strobes exactly one cycle later.
    always @(posedge clk) begin
        reg_rdata <= reg_re ? mem[reg_addr] : 16'hDEAD;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_we || reg_re)
                check("strobe_excl", 32'(reg_we & reg_re), 32'd0);
            if (reg_we) begin
                n_we++;
                check("we_addr", 32'(reg_addr), 32'(cur_addr));
                check("we_data", 32'(reg_wdata), 32'(cur_wdata));
            end
            if (reg_re) begin
                n_re++;
                check("re_addr", 32'(reg_addr), 32'(cur_addr));
            end
            if (mz)
                check("miso_zero", 32'(miso), 32'd0);
        end
    end

    task automatic frame(input logic [31:0] word, input int nbits,
                         input int rst_at, output logic [15:0] rx);
        logic [23:0] f;
        logic        rw;
        reg_addr_t   a;
        reg_data_t   d;
        int          we0, re0, exp_we, exp_re;
        bit          v8, full;
        f      = word[31:8];
        rw     = f[23];
        a      = f[19:16];
        d      = f[15:0];
        v8     = nbits >= 8 && (rst_at < 0 || rst_at >= 8);
        full   = nbits >= 24 && rst_at < 0;
        exp_re = (v8 && !rw) ? 1 : 0;
        exp_we = (full && rw) ? 1 : 0;
        cur_addr  = a;
        cur_wdata = d;
        we0 = n_we;
        re0 = n_re;
        rx  = '0;
        cs_n = 1'b0;
        wclk(H);
        for (int i = 0; i < nbits; i++) begin
            mosi = word[31-i];
            wclk(H);
            rx   = {rx[14:0], miso};
            sclk = 1'b1;
            if (i == 7 && !rw && rst_at < 0) mz = 1'b0;
            wclk(H);
            sclk = 1'b0;
            if (i + 1 == rst_at) begin
                rst = 1'b1;
                wclk(3);
                rst = 1'b0;
            end
        end
        wclk(H);
        cs_n = 1'b1;
        wclk(8);
        mz = 1'b1;
        wclk(2 * H);
        if (rst_at >= 0) begin
            m_addr  = '0;
            m_wdata = '0;
        end else begin
            if (v8) m_addr = a;
            if (exp_we != 0) begin
                m_wdata = d;
                mem[a]  = d;
            end
        end
        check("we_count", 32'(n_we - we0), 32'(exp_we));
        check("re_count", 32'(n_re - re0), 32'(exp_re));
        check("addr_model", 32'(reg_addr), 32'(m_addr));
        check("wdata_model", 32'(reg_wdata), 32'(m_wdata));
        if (full && !rw)
            check("rx_model", 32'(rx), 32'(mem[a]));
    endtask

    initial begin
        logic [15:0] rx;
        int          we0, re0;
        for (int i = 0; i < 16; i++) mem[i] = 16'(16'h1000 + i);
        mem[5] = 16'h1234;

        wclk(4);
        rst = 1'b0;
        wclk(1);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_wdata", 32'(reg_wdata), 32'd0);
        check("rst_we", 32'(reg_we), 32'd0);
        check("rst_re", 32'(reg_re), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        wclk(8);

        frame({24'h8ABEEF, 8'h00}, 24, -1, rx);
        check("w1_addr", 32'(reg_addr), 32'h0000_000A);
        check("w1_data", 32'(reg_wdata), 32'h0000_BEEF);

        frame({24'h050000, 8'h00}, 24, -1, rx);
        check("r1_rx", 32'(rx), 32'h0000_1234);
        check("r1_addr", 32'(reg_addr), 32'h0000_0005);
        check("r1_hold", 32'(reg_wdata), 32'h0000_BEEF);

        frame({24'h875555, 8'h00}, 20, -1, rx);
        check("abort_data", 32'(reg_wdata), 32'h0000_BEEF);

        frame({24'h830001, 8'h00}, 24, -1, rx);
        check("w2_addr", 32'(reg_addr), 32'h0000_0003);
        check("w2_data", 32'(reg_wdata), 32'h0000_0001);

        frame(32'h8FFF_FFFF, 32, -1, rx);
        check("long_data", 32'(reg_wdata), 32'h0000_FFFF);

        frame({24'h8C1234, 8'h00}, 24, 12, rx);
        check("mrst_addr", 32'(reg_addr), 32'd0);
        check("mrst_data", 32'(reg_wdata), 32'd0);

        frame({24'h826789, 8'h00}, 24, -1, rx);
        check("w3_addr", 32'(reg_addr), 32'h0000_0002);
        check("w3_data", 32'(reg_wdata), 32'h0000_6789);

        we0 = n_we;
        re0 = n_re;
        for (int i = 0; i < 10; i++) begin
            mosi = 1'b1;
            wclk(H);
            sclk = 1'b1;
            wclk(H);
            sclk = 1'b0;
        end
        wclk(2 * H);
        check("idle_we", 32'(n_we - we0), 32'd0);
        check("idle_re", 32'(n_re - re0), 32'd0);
        check("idle_addr", 32'(reg_addr), 32'h0000_0002);

        frame({24'h81AAAA, 8'h00}, 24, -1, rx);
        frame({24'h010000, 8'h00}, 24, -1, rx);
        check("b2b_rx", 32'(rx), 32'h0000_AAAA);
        check("b2b_addr", 32'(reg_addr), 32'h0000_0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_spi_bridge.md
REG_SPI_BRIDGE -- requirements
Module: reg_spi_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth for sclk/cs_n/mosi (range 2..3).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port sclk  input  1  SPI clock, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-005 SHALL have port cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-006 SHALL have port mosi  input  1  SPI data in, MSB first, sampled on sclk rising edge.
REQ-007 SHALL have port miso  output  1  SPI data out, MSB first, updated on sclk falling edge.
REQ-008 SHALL have port reg_addr  output  reg_addr_t  register address.
REQ-009 SHALL have port reg_wdata  output  reg_data_t  register write data.
REQ-010 SHALL have port reg_we  output  1  one-cycle write strobe.
REQ-011 SHALL have port reg_re  output  1  one-cycle read strobe.
REQ-012 SHALL have port reg_rdata  input  reg_data_t  read data, valid exactly one clk after reg_re.

Function
REQ-013 Frame SHALL be 24 bits: bit23 RW (1=write, 0=read), bits 22:20 reserved (ignored), bits 19:16 address, bits 15:0 data.
REQ-014 sclk, cs_n, mosi SHALL pass SYNC_STAGES flops; edges detected from last two stages; sclk period >= 8 clk required.
REQ-015 FSM states SHALL be IDLE, CMD, DATA, TAIL.
REQ-016 IDLE->CMD on synchronized cs_n falling; bit counter cleared, shift registers cleared.
REQ-017 CMD SHALL shift 8 bits on sclk rising; after 8th bit latch RW and address onto reg_addr, go to DATA.
REQ-018 On entering DATA with RW=0, reg_re SHALL pulse one cycle; reg_rdata captured next cycle into the output shift register.
REQ-019 In DATA with RW=0, miso SHALL drive data bit 15 after the first sclk falling edge following the 8th rising edge, then bits 14..0 on successive falling edges.
REQ-020 In DATA with RW=1, 16 bits SHALL shift in; on the 24th rising edge reg_wdata SHALL load and reg_we pulse exactly one cycle later than that detected edge; go to TAIL.
REQ-021 In DATA with RW=0, after 24th rising edge go to TAIL; no bus strobe.
REQ-022 TAIL SHALL ignore further sclk edges, miso=0, until cs_n rises -> IDLE.
REQ-023 cs_n rising in any non-IDLE state SHALL return to IDLE same cycle; an incomplete write (<24 bits) SHALL NOT pulse reg_we.
REQ-024 miso SHALL be 0 in IDLE, CMD and TAIL, and during DATA of a write frame.
REQ-025 reg_we and reg_re SHALL never assert in the same cycle; at most one strobe per frame.
REQ-026 reg_addr, reg_wdata SHALL hold values between frames.
REQ-027 sclk edges while cs_n high SHALL be ignored.

Reset
REQ-028 rst SHALL force IDLE, counter 0, shift registers 0, miso=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, synchronizer flops to cs_n=1/sclk=0/mosi=0.
REQ-029 rst mid-frame SHALL abort without strobe; the next frame is accepted only after a fresh cs_n falling edge.

Structure
REQ-030 reg_addr_t, reg_data_t, REG_DATAWIDTH, REG_ADDRWIDTH SHALL come from regPKG; add SPI_FRAME_BITS=24, SPI_CMD_BITS=8 there.
REQ-031 FSM state enum SHALL be local to the module.
REQ-032 One sub-module, spi_in_sync (N-flop synchronizer plus rise/fall detect), SHALL be instantiated per SPI input.

Verification
REQ-033 Write frame 0x8A_BEEF (RW=1, addr 0xA) -> reg_addr=0xA, reg_wdata=0xBEEF, single reg_we pulse, miso stays 0.
REQ-034 Read frame 0x05_0000 with reg_rdata=0x1234 one cycle after reg_re -> single reg_re, reg_addr=0x5, miso shifts 0x1234 MSB first.
REQ-035 Write frame aborted by cs_n high after 20 bits -> no reg_we; following full write 0x83_0001 -> reg_addr=0x3, reg_wdata=0x0001.
REQ-036 Frame of 32 sclk cycles (write 0x8F_FFFF + 8 extra bits) -> exactly one reg_we, extra bits ignored, miso=0.
REQ-037 rst asserted at bit 12 of a write frame -> all outputs reset values, no strobe; next frame accepted normally.
REQ-038 sclk toggled with cs_n high, then back-to-back frames write 0x81_AAAA and read 0x01 -> no strobe for idle toggles, read returns 0xAAAA from bench model.
